wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority over a FIFO of memory results,
// and a busy-bit scoreboard flags decode-stage sources with a long-latency write still pending.
module wb_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic        alu_use_sp,
    input  logic [63:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic        mem_use_sp,
    input  logic [63:0] mem_data,
    input  logic        lsu_issue,
    input  logic [4:0]  lsu_issue_rd,
    input  logic        lsu_issue_use_sp,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic        chk_use_sp,
    output logic        hazard,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [63:0] Write_d
);

    localparam int AW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] L_FULL = (AW + 1)'(QDEPTH);

    function automatic logic is_xzr(input logic [4:0] rd, input logic use_sp);
        return (rd == 5'd31) && !use_sp;
    endfunction

    logic [4:0]    r_q_rd   [QDEPTH];
    logic          r_q_sp   [QDEPTH];
    logic [63:0]   r_q_data [QDEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_alu_wr;
    logic          w_head_wr;
    logic [4:0]    w_head_rd;
    logic          w_issue_set;
    logic [31:0]   w_busy_nxt;

    assign w_full      = (r_count == L_FULL);
    assign w_empty     = (r_count == '0);
    assign mem_ready   = !reset && !w_full;
    assign w_enq       = mem_valid && mem_ready;
    assign w_alu_wr    = alu_valid && !is_xzr(alu_rd, alu_use_sp);
    // A discarded XZR ALU result leaves the write port free, so the head may still drain.
    assign w_deq       = !w_empty && !w_alu_wr;
    assign w_head_rd   = r_q_rd[r_rptr];
    assign w_head_wr   = w_deq && !is_xzr(w_head_rd, r_q_sp[r_rptr]);
    assign w_issue_set = lsu_issue && !is_xzr(lsu_issue_rd, lsu_issue_use_sp);

    assign hazard = (r_busy[chk_rs1] && !is_xzr(chk_rs1, chk_use_sp)) ||
                    (r_busy[chk_rs2] && !is_xzr(chk_rs2, chk_use_sp));

    // Next scoreboard: an issue to the same index outranks the dequeue clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < 32; i++) begin
            w_busy_nxt[i] = (w_issue_set && (lsu_issue_rd == 5'(i))) ? 1'b1 :
                            (w_deq && (w_head_rd == 5'(i)))          ? 1'b0 : r_busy[i];
        end
    end

    // Queue payload storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_rd[r_wptr]   <= mem_rd;
            r_q_sp[r_wptr]   <= mem_use_sp;
            r_q_data[r_wptr] <= mem_data;
        end
    end

    // Queue pointers, occupancy and scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_busy  <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_enq) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            Write_register <= 5'd0;
            Write_d        <= 64'd0;
        end else if (w_alu_wr) begin
            RegWrite       <= 1'b1;
            Write_register <= alu_rd;
            Write_d        <= alu_data;
        end else if (w_head_wr) begin
            RegWrite       <= 1'b1;
            Write_register <= w_head_rd;
            Write_d        <= r_q_data[r_rptr];
        end else begin
            RegWrite       <= 1'b0;
            Write_register <= 5'd0;
            Write_d        <= 64'd0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, queueing, back-pressure, XZR discard, scoreboard, reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_use_sp, mem_valid, mem_use_sp, mem_ready;
    logic [4:0]  alu_rd, mem_rd, lsu_issue_rd, chk_rs1, chk_rs2, Write_register;
    logic [63:0] alu_data, mem_data, Write_d;
    logic        lsu_issue, lsu_issue_use_sp, chk_use_sp, hazard, RegWrite;
    int          errors = 0;
    int          checks = 0;

    wb_arbiter #(.QDEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_use_sp(alu_use_sp), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_use_sp(mem_use_sp), .mem_data(mem_data),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd), .lsu_issue_use_sp(lsu_issue_use_sp),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_use_sp(chk_use_sp), .hazard(hazard),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_d(Write_d)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_use_sp = 1'b0; alu_data = 64'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_use_sp = 1'b0; mem_data = 64'd0;
        lsu_issue = 1'b0; lsu_issue_rd = 5'd0; lsu_issue_use_sp = 1'b0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_use_sp = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_we got=%0b exp=0", RegWrite); end
        checks++; if (Write_register !== 5'd0) begin errors++; $display("FAIL rst_wr got=%0d exp=0", Write_register); end
        checks++; if (Write_d !== 64'd0) begin errors++; $display("FAIL rst_wd got=%h exp=0", Write_d); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%0b exp=0", hazard); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", mem_ready); end
        reset = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%0b exp=1", mem_ready); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        alu_valid = 1'b0;
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_we got=%0b exp=1", RegWrite); end
        checks++; if (Write_register !== 5'd5) begin errors++; $display("FAIL alu_wr got=%0d exp=5", Write_register); end
        checks++; if (Write_d !== 64'h1234) begin errors++; $display("FAIL alu_wd got=%h exp=1234", Write_d); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_idle_we got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_conflict();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'hAA;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL conf_ready got=%0b exp=1", mem_ready); end
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd1) begin errors++; $display("FAIL conf_alu got=%0b/%0d exp=1/1", RegWrite, Write_register); end
        tick();
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd2 || Write_d !== 64'hAA) begin errors++; $display("FAIL conf_mem got=%0b/%0d/%h exp=1/2/aa", RegWrite, Write_register, Write_d); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL conf_idle got=%0b exp=0", RegWrite); end
        // ALU busy for three cycles: memory result waits for the first ALU-free cycle.
        alu_valid = 1'b1; alu_rd = 5'd1; mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'hBB;
        tick();
        mem_valid = 1'b0; alu_rd = 5'd4;
        checks++; if (Write_register !== 5'd1) begin errors++; $display("FAIL hold_c0 got=%0d exp=1", Write_register); end
        tick();
        alu_rd = 5'd6;
        checks++; if (Write_register !== 5'd4) begin errors++; $display("FAIL hold_c1 got=%0d exp=4", Write_register); end
        tick();
        alu_valid = 1'b0;
        checks++; if (Write_register !== 5'd6) begin errors++; $display("FAIL hold_c2 got=%0d exp=6", Write_register); end
        tick();
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd2 || Write_d !== 64'hBB) begin errors++; $display("FAIL hold_mem got=%0b/%0d/%h exp=1/2/bb", RegWrite, Write_register, Write_d); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [4:0]  exp_rd [3];
        logic [63:0] exp_d  [3];
        exp_rd[0] = 5'd10; exp_rd[1] = 5'd11; exp_rd[2] = 5'd12;
        exp_d[0] = 64'hA0; exp_d[1] = 64'hA1; exp_d[2] = 64'hA2;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h8;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = exp_rd[i]; mem_data = exp_d[i];
            #1;
            checks++; if (mem_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready%0d got=%0b exp=%0b", i, mem_ready, (i < 2)); end
            tick();
            checks++; if (Write_register !== 5'd8) begin errors++; $display("FAIL bp_alu%0d got=%0d exp=8", i, Write_register); end
        end
        // ALU stops while the queue is full: the full queue still refuses the offer.
        alu_valid = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL bp_full_deq got=%0b exp=0", mem_ready); end
        tick();
        checks++; if (Write_register !== 5'd10 || Write_d !== 64'hA0) begin errors++; $display("FAIL bp_order0 got=%0d/%h exp=10/a0", Write_register, Write_d); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again got=%0b exp=1", mem_ready); end
        tick();
        mem_valid = 1'b0;
        checks++; if (Write_register !== 5'd11 || Write_d !== 64'hA1) begin errors++; $display("FAIL bp_order1 got=%0d/%h exp=11/a1", Write_register, Write_d); end
        tick();
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd12 || Write_d !== 64'hA2) begin errors++; $display("FAIL bp_order2 got=%0b/%0d/%h exp=1/12/a2", RegWrite, Write_register, Write_d); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_xzr();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h33;
        tick();
        mem_valid = 1'b0; alu_rd = 5'd31; alu_use_sp = 1'b0; alu_data = 64'hDEAD;
        checks++; if (Write_register !== 5'd9) begin errors++; $display("FAIL xzr_pre got=%0d exp=9", Write_register); end
        tick();
        alu_use_sp = 1'b1; alu_data = 64'h55;
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd3 || Write_d !== 64'h33) begin errors++; $display("FAIL xzr_head got=%0b/%0d/%h exp=1/3/33", RegWrite, Write_register, Write_d); end
        tick();
        alu_use_sp = 1'b0;
        checks++; if (RegWrite !== 1'b1 || Write_register !== 5'd31 || Write_d !== 64'h55) begin errors++; $display("FAIL sp_write got=%0b/%0d/%h exp=1/31/55", RegWrite, Write_register, Write_d); end
        tick();
        alu_valid = 1'b0;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL xzr_alone got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_scoreboard();
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_clear got=%0b exp=0", hazard); end
        lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
        tick();
        lsu_issue = 1'b0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set got=%0b exp=1", hazard); end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
        tick();
        mem_valid = 1'b0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_queued got=%0b exp=1", hazard); end
        tick();
        checks++; if (hazard !== 1'b0 || Write_register !== 5'd7) begin errors++; $display("FAIL sb_dequeue got=%0b/%0d exp=0/7", hazard, Write_register); end
        // Re-issue rd=7 on the very edge the old rd=7 entry dequeues.
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0; lsu_issue = 1'b1;
        tick();
        lsu_issue = 1'b0;
        checks++; if (hazard !== 1'b1 || Write_register !== 5'd7) begin errors++; $display("FAIL sb_set_wins got=%0b/%0d exp=1/7", hazard, Write_register); end
        // SP vs XZR on index 31 in the checker.
        lsu_issue = 1'b1; lsu_issue_rd = 5'd31; lsu_issue_use_sp = 1'b1; chk_rs1 = 5'd0; chk_rs2 = 5'd31;
        tick();
        lsu_issue = 1'b0;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_xzr_chk got=%0b exp=0", hazard); end
        chk_use_sp = 1'b1;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_sp_chk got=%0b exp=1", hazard); end
        chk_use_sp = 1'b0; chk_rs2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd8;
        lsu_issue = 1'b1; lsu_issue_rd = 5'd13; lsu_issue_use_sp = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 64'hD13;
        tick();
        lsu_issue_rd = 5'd14; mem_rd = 5'd14; mem_data = 64'hD14;
        tick();
        lsu_issue = 1'b0; mem_valid = 1'b0; chk_rs1 = 5'd13; chk_rs2 = 5'd14;
        #1;
        checks++; if (hazard !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL mid_pre got=%0b/%0b exp=1/0", hazard, mem_ready); end
        #2 reset = 1'b1; alu_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0 || Write_d !== 64'd0 || hazard !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL mid_async got=%0b/%h/%0b/%0b exp=0/0/0/0", RegWrite, Write_d, hazard, mem_ready); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%0b exp=1", mem_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (RegWrite !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL mid_nowrite%0d got=%0b/%0b exp=0/0", i, RegWrite, hazard); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_conflict();
        test_back_pressure();
        test_xzr();
        test_scoreboard();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
